// File: rtl/button_conditioner.sv
// Per-channel conditioning of raw active-low push buttons: two-flop synchronizer,
// debounce counter, and press/auto-repeat pulse FSM. All outputs are registered.
module button_conditioner #(
    parameter int               WIDTH           = 3,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000,
    parameter logic [WIDTH-1:0] REPEAT_MASK     = 3'b011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] button_n,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] pulse
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LIMIT     = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TMR_W-1:0] DELAY_LIMIT  = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0] PERIOD_LIMIT = TMR_W'(REPEAT_PERIOD);

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_HOLD_WAIT   = 2'd1;
    localparam logic [1:0] ST_HOLD_REPEAT = 2'd2;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_chan
            logic             sync1_q, sync2_q;
            logic             s;
            logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
            logic             pressed_q, pressed_d;
            logic [1:0]       state_q, state_d;
            logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
            logic             pulse_q, pulse_d;

            assign s = ~sync2_q;

            // Accept the new level only on the cycle after the counter has
            // already seen DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_comb begin
                db_cnt_d  = '0;
                pressed_d = pressed_q;
                if (s != pressed_q) begin
                    if (db_cnt_q >= DB_LIMIT) begin
                        pressed_d = s;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end

            assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

            // FSM keys off the next debounced level so the press pulse lines
            // up with the rising edge of pressed; release always wins.
            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                pulse_d = 1'b0;
                if (!pressed_d) begin
                    state_d = ST_RELEASED;
                    timer_d = '0;
                end else begin
                    case (state_q)
                        ST_RELEASED: begin
                            state_d = ST_HOLD_WAIT;
                            timer_d = '0;
                            pulse_d = 1'b1;
                        end
                        ST_HOLD_WAIT: begin
                            if (REPEAT_MASK[gi]) begin
                                if (timer_inc >= DELAY_LIMIT) begin
                                    state_d = ST_HOLD_REPEAT;
                                    timer_d = '0;
                                    pulse_d = 1'b1;
                                end else begin
                                    timer_d = timer_inc;
                                end
                            end else if (timer_q < DELAY_LIMIT) begin
                                timer_d = timer_inc;
                            end
                        end
                        ST_HOLD_REPEAT: begin
                            if (timer_inc >= PERIOD_LIMIT) begin
                                timer_d = '0;
                                pulse_d = 1'b1;
                            end else begin
                                timer_d = timer_inc;
                            end
                        end
                        default: begin
                            state_d = ST_RELEASED;
                            timer_d = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q   <= 1'b1;
                    sync2_q   <= 1'b1;
                    db_cnt_q  <= '0;
                    pressed_q <= 1'b0;
                    state_q   <= ST_RELEASED;
                    timer_q   <= '0;
                    pulse_q   <= 1'b0;
                end else begin
                    sync1_q   <= button_n[gi];
                    sync2_q   <= sync1_q;
                    db_cnt_q  <= db_cnt_d;
                    pressed_q <= pressed_d;
                    state_q   <= state_d;
                    timer_q   <= timer_d;
                    pulse_q   <= pulse_d;
                end
            end

            assign pressed[gi] = pressed_q;
            assign pulse[gi]   = pulse_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected pulse/level
// events by edge number, a negedge monitor compares every cycle.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] button_n;
    logic [2:0] pressed;
    logic [2:0] pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .WIDTH          (3),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_MASK    (3'b011)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .button_n(button_n),
        .pressed (pressed),
        .pulse   (pulse)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } ev_t;

    ev_t        pulse_exp[$];
    ev_t        press_exp[$];
    logic [2:0] exp_pressed = 3'b000;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;

    task automatic push_pulse(input int c, input logic [2:0] v);
        pulse_exp.push_back('{c, v});
    endtask

    task automatic push_press(input int c, input logic [2:0] v);
        press_exp.push_back('{c, v});
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_cnt, act, req);
        end
    endtask

    task automatic wait_until(input int c);
        while (edge_cnt < c) @(negedge clk);
    endtask

    // Monitor: pops the event due at this edge, otherwise expects no pulse
    // and an unchanged level.
    always @(negedge clk) begin
        logic [2:0] exp_pulse;
        if (mon_en) begin
            exp_pulse = 3'b000;
            while (pulse_exp.size() > 0 && pulse_exp[0].cyc < edge_cnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL stale_pulse_event: due edge %0d, now %0d", pulse_exp[0].cyc, edge_cnt);
                void'(pulse_exp.pop_front());
            end
            while (press_exp.size() > 0 && press_exp[0].cyc < edge_cnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL stale_pressed_event: due edge %0d, now %0d", press_exp[0].cyc, edge_cnt);
                void'(press_exp.pop_front());
            end
            if (pulse_exp.size() > 0 && pulse_exp[0].cyc == edge_cnt) begin
                exp_pulse = pulse_exp[0].val;
                void'(pulse_exp.pop_front());
            end
            if (press_exp.size() > 0 && press_exp[0].cyc == edge_cnt) begin
                exp_pressed = press_exp[0].val;
                void'(press_exp.pop_front());
            end
            check("pulse", pulse, exp_pulse);
            check("pressed", pressed, exp_pressed);
            if (exp_pulse != 3'b000 || pulse != 3'b000)
                $display("edge %0d: pulse=%b (exp %b) pressed=%b", edge_cnt, pulse, exp_pulse, pressed);
        end
    end

    initial begin
        int t0;
        reset    = 1'b1;
        button_n = 3'b111;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: hold ch0; repeats at 16,19,22,...; release lands on a repeat slot (31)
        t0 = edge_cnt + 1;
        button_n = 3'b110;
        push_pulse(t0 + 6, 3'b001);
        push_pulse(t0 + 16, 3'b001);
        push_pulse(t0 + 19, 3'b001);
        push_pulse(t0 + 22, 3'b001);
        push_pulse(t0 + 25, 3'b001);
        push_pulse(t0 + 28, 3'b001);
        push_press(t0 + 6, 3'b001);
        push_press(t0 + 31, 3'b000);
        wait_until(t0 + 24);
        button_n = 3'b111;
        wait_until(t0 + 40);

        // 2: ch2 has repeat disabled: single pulse over a 40-cycle hold
        t0 = edge_cnt + 1;
        button_n = 3'b011;
        push_pulse(t0 + 6, 3'b100);
        push_press(t0 + 6, 3'b100);
        push_press(t0 + 46, 3'b000);
        wait_until(t0 + 39);
        button_n = 3'b111;
        wait_until(t0 + 55);

        // 3: bounce on ch1 (3 low, 1 high, 3 low) is rejected
        t0 = edge_cnt + 1;
        button_n = 3'b101;
        wait_until(t0 + 2);
        button_n = 3'b111;
        wait_until(t0 + 3);
        button_n = 3'b101;
        wait_until(t0 + 6);
        button_n = 3'b111;
        wait_until(t0 + 20);

        // 4: short press: level drops before first repeat is due, no release pulse
        t0 = edge_cnt + 1;
        button_n = 3'b110;
        push_pulse(t0 + 6, 3'b001);
        push_press(t0 + 6, 3'b001);
        push_press(t0 + 14, 3'b000);
        wait_until(t0 + 7);
        button_n = 3'b111;
        wait_until(t0 + 30);

        // 5: reset mid-hold on ch0+ch1, then re-press from still-held buttons
        t0 = edge_cnt + 1;
        button_n = 3'b100;
        push_pulse(t0 + 6, 3'b011);
        push_pulse(t0 + 21, 3'b011);
        push_pulse(t0 + 31, 3'b011);
        push_pulse(t0 + 34, 3'b011);
        push_pulse(t0 + 37, 3'b011);
        push_pulse(t0 + 40, 3'b011);
        push_press(t0 + 6, 3'b011);
        push_press(t0 + 14, 3'b000);
        push_press(t0 + 21, 3'b011);
        push_press(t0 + 41, 3'b000);
        wait_until(t0 + 13);
        reset = 1'b1;
        wait_until(t0 + 14);
        reset = 1'b0;
        wait_until(t0 + 34);
        button_n = 3'b111;
        wait_until(t0 + 50);

        // 6: ch0 and ch1 pressed together stay aligned through repeats
        t0 = edge_cnt + 1;
        button_n = 3'b100;
        push_pulse(t0 + 6, 3'b011);
        push_pulse(t0 + 16, 3'b011);
        push_pulse(t0 + 19, 3'b011);
        push_pulse(t0 + 22, 3'b011);
        push_pulse(t0 + 25, 3'b011);
        push_press(t0 + 6, 3'b011);
        push_press(t0 + 26, 3'b000);
        wait_until(t0 + 19);
        button_n = 3'b111;
        wait_until(t0 + 35);

        n_checks++;
        if (pulse_exp.size() != 0 || press_exp.size() != 0) begin
            n_fail++;
            $display("FAIL unconsumed_events: pulse %0d, pressed %0d left, required 0",
                     pulse_exp.size(), press_exp.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the three raw, active-low push buttons before they reach the goal counter. Each channel is synchronized, debounced, and converted into an active-high level plus a one-cycle press pulse, with optional auto-repeat while the button is held. It sits between the board BUTTON pins and the goal up/down/reset inputs. It replaces the bare inversions, so each accepted press moves the goal by exactly one step, and holding a button slews it at a controlled rate.

## Interface

Parameters:
- WIDTH, 3: number of independent button channels.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000: cycles from the initial press pulse to the first repeat pulse (500 ms); minimum 1.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses (100 ms); minimum 1.
- REPEAT_MASK, 3'b011: per-channel auto-repeat enable; bit set means the channel repeats. Reset-style buttons are left clear.

Ports:
- clk, input, 1: system clock (CLOCK_50).
- reset, input, 1: synchronous, active-high reset.
- button_n, input, WIDTH: raw asynchronous buttons, active-low (0 = pushed).
- pressed, output, WIDTH: debounced level, active-high.
- pulse, output, WIDTH: one-cycle strobe on each accepted press and each repeat.

## Operation

- All channels are identical and fully independent. There is no interaction between channels and no priority between them.
- Synchronizer: two flops per channel. The inverted output of the second flop is the sampled level `s`.
- Debounce:
  - A per-channel counter counts consecutive cycles with `s != pressed`.
  - Any cycle with `s == pressed` clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES, `pressed` takes `s` and the counter clears.
- Counter widths are $clog2(max value + 1). Counters saturate and never wrap.
- Per-channel FSM, states RELEASED, HOLD_WAIT, HOLD_REPEAT:
  - RELEASED -> HOLD_WAIT when `pressed` rises. `pulse` is 1 that same cycle and the hold timer clears.
  - HOLD_WAIT: the hold timer increments.
    - If it reaches REPEAT_DELAY and the channel's REPEAT_MASK bit is 1: `pulse` is 1 for one cycle, the timer clears, go to HOLD_REPEAT.
    - If the mask bit is 0: stay in HOLD_WAIT with no further pulses; the timer stops at saturation.
  - HOLD_REPEAT: the timer increments. Each time it reaches REPEAT_PERIOD, `pulse` is 1 for one cycle and the timer clears.
  - Any state -> RELEASED when `pressed` falls. The timer clears and no pulse occurs on release.
- Release always takes priority over a pending repeat pulse in the same cycle.

## Timing

- Reset (synchronous, sampled on a clk edge):
  - sync flops = 1 (released);
  - `pressed` = 0, `pulse` = 0;
  - debounce and hold counters = 0;
  - FSM = RELEASED.
- Press latency: if the first edge sampling raw low is edge 0, then `pressed` and `pulse` rise after edge DEBOUNCE_CYCLES+2, provided raw stays low throughout.
- Release latency: identical. `pressed` falls DEBOUNCE_CYCLES+2 edges after raw returns high.
- `pulse` is always exactly one cycle wide. At most one pulse per channel per cycle.
- The first repeat pulse comes REPEAT_DELAY cycles after the press pulse. Later repeats are spaced REPEAT_PERIOD cycles apart.
- Glitches shorter than DEBOUNCE_CYCLES sampled cycles produce no change on any output.
- Reset asserted mid-hold: outputs are 0 on the following cycle.
- Button still held when reset deasserts: treated as a new press. `pulse` fires DEBOUNCE_CYCLES+2 edges after reset deasserts.
- Outputs are registered. There is no combinational path from button_n to any output.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=3'b011, with edges counted from the first edge sampling the change.

1. Press and hold channel 0 -> pressed[0] and pulse[0] high after edge 6. Repeat pulses after edges 16, 19, 22. No other channel changes.
2. Hold channel 2 (mask bit 0) for 40 cycles -> exactly one pulse[2] after edge 6, then none. pressed[2] stays 1 until 6 edges after release.
3. Bounce on channel 1: low 3 cycles, high 1, low 3, then high -> pressed[1] and pulse[1] stay 0 throughout.
4. Press channel 0, release at edge 12 (before the first repeat) -> exactly one pulse. pressed[0] falls after edge 18. No pulse on release.
5. Assert reset for 1 cycle at edge 14 while channels 0 and 1 are held -> all outputs 0 next cycle. With the buttons still held, new press pulses appear 6 edges after reset deasserts.
6. Press channels 0 and 1 on the same edge -> both pulse in the same cycle after edge 6. Their repeats stay aligned at edges 16 and 19.
